// File: rtl/md_ctrl_if.sv
// md_ctrl_if: bundles the EX-side request/response signals and the
// multiplier/divider datapath signals of the multiply/divide sequencer.
//   master : EX stage plus external mul/div units (drives requests and results)
//   slave  : md_ctrl (drives stall, HI/LO and latched operands)
// Signals:
//   op_valid/op/rs_val/rt_val : candidate md op and its operands from EX
//   mthi/mtlo                 : write rs_val into HI / LO
//   flush                     : cancel EX instruction and anything in flight
//   stall                     : pipeline hold request (combinational)
//   hi/lo                     : architectural HI/LO (registered)
//   md_a/md_b/md_signed       : operands/sign select held on the units
//   mul_p/div_dout            : unit results ({hi,lo} and {quot,rem})
interface md_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               op_valid;
  logic [3:0]         op;
  logic [WIDTH-1:0]   rs_val;
  logic [WIDTH-1:0]   rt_val;
  logic               mthi;
  logic               mtlo;
  logic               flush;
  logic               stall;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   md_a;
  logic [WIDTH-1:0]   md_b;
  logic               md_signed;
  logic [2*WIDTH-1:0] mul_p;
  logic [2*WIDTH-1:0] div_dout;

  modport master (
    output op_valid, op, rs_val, rt_val, mthi, mtlo, flush, mul_p, div_dout,
    input  stall, hi, lo, md_a, md_b, md_signed
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val, mthi, mtlo, flush, mul_p, div_dout,
    output stall, hi, lo, md_a, md_b, md_signed
  );
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer and owner of the HI/LO registers.
// Accepts one MULT/MULTU/DIV/DIVU, holds its operands on the external
// pipelined units for a fixed latency while stalling the pipeline, then
// commits the 64-bit result into HI/LO. Also services MTHI/MTLO and
// aborts an in-flight operation on flush.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : md_ctrl_if slave modport (EX request, stall, HI/LO, unit I/O)
//
// state | meaning
// IDLE  | ready to accept an md op or MTHI/MTLO
// BUSY  | operands held on the unit, counting down to result capture
// DONE  | result committed; one cycle with accept blocked so the op still
//       | sitting in EX is not issued a second time
module md_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 32
) (
  input  logic   clk,
  input  logic   rst,
  md_ctrl_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    K_MUL = 1'b0,
    K_DIV = 1'b1
  } kind_t;

  state_t           state;
  kind_t            kind;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] md_a_q;
  logic [WIDTH-1:0] md_b_q;
  logic             md_signed_q;

  logic is_md;
  logic is_div;
  logic is_signed;
  logic accept;

  always_comb begin
    is_md     = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (bus.op)
      OP_MULT:  begin is_md = 1'b1; is_signed = 1'b1; end
      OP_MULTU: begin is_md = 1'b1; end
      OP_DIV:   begin is_md = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  begin is_md = 1'b1; is_div = 1'b1; end
      default:  ;
    endcase
  end

  // rst gating keeps stall low while reset is held even if EX presents an op.
  assign accept = ~rst & (state == IDLE) & bus.op_valid & is_md & ~bus.flush;

  assign bus.stall     = accept | (state == BUSY);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.md_a      = md_a_q;
  assign bus.md_b      = md_b_q;
  assign bus.md_signed = md_signed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      kind        <= K_MUL;
      cnt         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      md_a_q      <= '0;
      md_b_q      <= '0;
      md_signed_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            md_a_q      <= bus.rs_val;
            md_b_q      <= bus.rt_val;
            md_signed_q <= is_signed;
            kind        <= is_div ? K_DIV : K_MUL;
            cnt         <= is_div ? 6'(DIV_LAT) : 6'(MUL_LAT);
            state       <= BUSY;
          end else if (!bus.flush) begin
            if (bus.mthi) hi_q <= bus.rs_val;
            if (bus.mtlo) lo_q <= bus.rs_val;
          end
        end

        BUSY: begin
          if (bus.flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == 6'd1) begin
            // Divider packs {quotient, remainder}; quotient belongs in LO.
            if (kind == K_DIV) begin
              lo_q <= bus.div_dout[2*WIDTH-1:WIDTH];
              hi_q <= bus.div_dout[WIDTH-1:0];
            end else begin
              hi_q <= bus.mul_p[2*WIDTH-1:WIDTH];
              lo_q <= bus.mul_p[WIDTH-1:0];
            end
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end

        DONE: begin
          // HI/LO already committed, so flush only blocks MTHI/MTLO here.
          if (!bus.flush) begin
            if (bus.mthi) hi_q <= bus.rs_val;
            if (bus.mtlo) lo_q <= bus.rs_val;
          end
          state <= IDLE;
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b0111;

  logic clk;
  logic rst;

  md_ctrl_if #(.WIDTH(32)) bus ();

  md_ctrl #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- external units (ideal, pipelined) ----------------
  function automatic logic [63:0] f_mul(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb;
    logic [63:0] r;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = 64'(sa * sb);
    end else begin
      r = {32'b0, a} * {32'b0, b};
    end
    return r;
  endfunction

  // {quotient, remainder}; a zero divisor yields a fixed garbage pattern
  function automatic logic [63:0] f_div(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'hDEADBEEF_0BADF00D;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qv = 64'(q);
      rv = 64'(r);
      return {qv[31:0], rv[31:0]};
    end
    return {a / b, a % b};
  endfunction

  logic [63:0] mpipe [4];
  logic [63:0] dpipe [8];
  always_ff @(posedge clk) begin
    mpipe[0] <= f_mul(bus.md_a, bus.md_b, bus.md_signed);
    dpipe[0] <= f_div(bus.md_a, bus.md_b, bus.md_signed);
    for (int i = 1; i < 4; i++) mpipe[i] <= mpipe[i-1];
    for (int i = 1; i < 8; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.mul_p    = mpipe[3];
  assign bus.div_dout = dpipe[7];

  // ---------------- reference model (cycle-number based) ----------------
  int          cyc = 0;
  bit          m_inflight;
  int          m_acc_cyc, m_lat, m_done_cyc;
  bit          m_div, m_sgn;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  task automatic model_reset();
    m_inflight = 0; m_done_cyc = -100; m_acc_cyc = 0; m_lat = 0;
    m_div = 0; m_sgn = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
  endtask

  function automatic bit is_md(logic [3:0] o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a negedge with inputs already driven: checks stall,
  // advances the model across the next posedge, then checks HI/LO.
  task automatic step(output logic s);
    bit busy, acc, e_stall;
    logic [63:0] r;
    busy = m_inflight;
    acc  = !busy && (cyc != m_done_cyc) && bus.op_valid && is_md(bus.op) && !bus.flush;
    e_stall = acc || busy;
    #1;
    s = bus.stall;
    chk("stall", 64'(bus.stall), 64'(e_stall));
    if (busy) begin
      chk("md_a", 64'(bus.md_a), 64'(m_a));
      chk("md_b", 64'(bus.md_b), 64'(m_b));
      chk("md_signed", 64'(bus.md_signed), 64'(m_sgn));
    end
    if (busy) begin
      if (bus.flush) begin
        m_inflight = 0;
      end else if (cyc == m_acc_cyc + m_lat) begin
        if (m_div) begin
          r = f_div(m_a, m_b, m_sgn);
          m_lo = r[63:32];
          m_hi = r[31:0];
        end else begin
          r = f_mul(m_a, m_b, m_sgn);
          m_hi = r[63:32];
          m_lo = r[31:0];
        end
        m_inflight = 0;
        m_done_cyc = cyc + 1;
      end
    end else if (acc) begin
      m_inflight = 1;
      m_acc_cyc  = cyc;
      m_div      = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
      m_sgn      = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      m_lat      = m_div ? 32 : 5;
      m_a        = bus.rs_val;
      m_b        = bus.rt_val;
    end else if (!bus.flush) begin
      if (bus.mthi) m_hi = bus.rs_val;
      if (bus.mtlo) m_lo = bus.rs_val;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("hi", 64'(bus.hi), 64'(m_hi));
    chk("lo", 64'(bus.lo), 64'(m_lo));
  endtask

  task automatic idle_inputs();
    bus.op_valid = 0; bus.op = 4'b0000; bus.rs_val = 0; bus.rt_val = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.flush = 0;
  endtask

  // Holds op_valid until the stall drops (the DONE cycle), op_valid stays high.
  task automatic run_op(logic [3:0] o, logic [31:0] a, logic [31:0] b, output int n_st);
    logic s;
    int guard;
    bus.op_valid = 1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    n_st = 0; guard = 0;
    do begin
      step(s);
      if (s) n_st++;
      guard++;
    end while (s && guard < 80);
    chk("op_timeout", 64'(guard < 80), 64'(1));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt, hi, lo;
    logic        sgn;
    int          stall_cycles;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    int n_st;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 6};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 6};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 33};
    vecs[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[4] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1, 6};
    vecs[5] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 6};
    vecs[6] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 33};
    vecs[7] = '{OP_DIVU,  32'd5,        32'd0,        32'h0BADF00D, 32'hDEADBEEF, 1'b0, 33};

    // reset: outputs cleared, stall low even with an op presented
    idle_inputs();
    model_reset();
    rst = 1;
    bus.op_valid = 1; bus.op = OP_DIV;
    @(negedge clk);
    #1;
    chk("rst_stall", 64'(bus.stall), 64'(0));
    chk("rst_hi", 64'(bus.hi), 64'(0));
    chk("rst_lo", 64'(bus.lo), 64'(0));
    chk("rst_md_a", 64'(bus.md_a), 64'(0));
    chk("rst_md_signed", 64'(bus.md_signed), 64'(0));
    @(negedge clk);
    rst = 0;
    idle_inputs();
    step(s);

    // table: full operations with constant expected results
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, n_st);
      chk($sformatf("vec%0d_stall_cycles", i), 64'(n_st), 64'(vecs[i].stall_cycles));
      chk($sformatf("vec%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_signed", i), 64'(bus.md_signed), 64'(vecs[i].sgn));
      idle_inputs();
      step(s);
    end

    // flush in the 10th busy cycle of a divide
    bus.mthi = 1; bus.mtlo = 1; bus.rs_val = 32'h0000AAAA;
    step(s);
    bus.mthi = 0; bus.rs_val = 32'h00005555;
    step(s);
    bus.mtlo = 0;
    bus.op_valid = 1; bus.op = OP_DIVU; bus.rs_val = 32'd1000; bus.rt_val = 32'd3;
    step(s);
    for (int i = 0; i < 9; i++) step(s);
    bus.flush = 1;
    step(s);
    chk("flush_cycle_stall", 64'(s), 64'(1));
    idle_inputs();
    step(s);
    chk("post_flush_stall", 64'(s), 64'(0));
    for (int i = 0; i < 30; i++) step(s);
    chk("flush_hi", 64'(bus.hi), 64'h0000AAAA);
    chk("flush_lo", 64'(bus.lo), 64'h00005555);

    // MTHI/MTLO in idle, MTHI ignored while busy
    bus.mthi = 1; bus.rs_val = 32'h1234;
    step(s);
    chk("mthi_hi", 64'(bus.hi), 64'h1234);
    bus.mthi = 0; bus.mtlo = 1; bus.rs_val = 32'h5678;
    step(s);
    chk("mtlo_lo", 64'(bus.lo), 64'h5678);
    chk("mtlo_hi_kept", 64'(bus.hi), 64'h1234);
    bus.mtlo = 0;
    bus.op_valid = 1; bus.op = OP_MULT; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    step(s);
    bus.mthi = 1; bus.rs_val = 32'h9999;
    step(s);
    chk("busy_mthi_ignored", 64'(bus.hi), 64'h1234);
    bus.mthi = 0;
    run_op(OP_MULT, 32'd3, 32'd4, n_st);
    chk("mul_after_mthi_hi", 64'(bus.hi), 64'd0);
    chk("mul_after_mthi_lo", 64'(bus.lo), 64'd12);

    // op held through DONE: no reissue; next op right after DONE accepted
    idle_inputs();
    step(s);
    run_op(OP_MULT, 32'd6, 32'd7, n_st);
    chk("done_stall_low", 64'(s), 64'(0));
    bus.op = OP_MULTU; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
    step(s);
    chk("done_plus1_accept", 64'(s), 64'(1));
    run_op(OP_MULTU, 32'd9, 32'd9, n_st);
    chk("back_to_back_lo", 64'(bus.lo), 64'd81);
    idle_inputs();
    step(s);

    // async reset mid-divide
    bus.mthi = 1; bus.mtlo = 1; bus.rs_val = 32'hCAFE;
    step(s);
    idle_inputs();
    bus.op_valid = 1; bus.op = OP_DIV; bus.rs_val = 32'd500; bus.rt_val = 32'd9;
    step(s);
    for (int i = 0; i < 17; i++) step(s);
    #2;
    rst = 1;
    #1;
    chk("async_rst_stall", 64'(bus.stall), 64'(0));
    chk("async_rst_hi", 64'(bus.hi), 64'(0));
    chk("async_rst_lo", 64'(bus.lo), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst = 0;
    idle_inputs();
    step(s);
    run_op(OP_MULTU, 32'd7, 32'd6, n_st);
    chk("post_rst_stall_cycles", 64'(n_st), 64'(6));
    chk("post_rst_lo", 64'(bus.lo), 64'd42);
    idle_inputs();
    step(s);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ops [5];
      ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
      ops[4] = 4'($urandom);
      bus.op_valid = ($urandom_range(1, 0) == 1);
      bus.op       = ops[$urandom_range(4, 0)];
      bus.rs_val   = $urandom;
      bus.rt_val   = ($urandom_range(15, 0) == 0) ? 32'd0 : $urandom;
      bus.mthi     = ($urandom_range(7, 0) == 0);
      bus.mtlo     = ($urandom_range(7, 0) == 0);
      bus.flush    = ($urandom_range(24, 0) == 0);
      step(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
